// File: rtl/reg_control_spi.sv
// SPI control register: software loads the whole image, the SPI engine updates the
// RX-end count and clears the send request. Reserved bits are masked to zero.
module reg_control_spi #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_1_i,
  input  logic                  wr_1_i,
  input  logic [9:0]            n_rx_end_i,
  input  logic                  wr_2_i,
  input  logic                  send_clear_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  // Defined fields: send/cs_ctrl/all_1s [2:0], n_tx_end [12:4], n_rx_end [25:16].
  // Masked bits are constant zero and fold away in synthesis.
  localparam logic [DATA_WIDTH-1:0] FIELD_MASK = DATA_WIDTH'(26'h3FF_1FF7);

  localparam int SEND_BIT  = 0;
  localparam int RX_END_LO = 16;
  localparam int RX_END_HI = 25;

  logic [DATA_WIDTH-1:0] reg_d;
  logic [DATA_WIDTH-1:0] reg_q;

  always_comb begin
    reg_d = reg_q;
    if (wr_1_i) begin
      reg_d = data_1_i;
    end else begin
      // Engine updates are independent fields, so both may land in one cycle.
      if (wr_2_i) begin
        reg_d[RX_END_HI:RX_END_LO] = n_rx_end_i;
      end
      if (send_clear_i) begin
        reg_d[SEND_BIT] = 1'b0;
      end
    end
    reg_d = reg_d & FIELD_MASK;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_q <= '0;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign data_o = reg_q;

endmodule

// File: tb/tb_reg_control_spi.sv
// Bench for reg_control_spi: directed cases followed by random traffic checked
// against a field-level model of the register.
module tb_reg_control_spi;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] data_1_i;
  logic        wr_1_i;
  logic [9:0]  n_rx_end_i;
  logic        wr_2_i;
  logic        send_clear_i;
  logic [31:0] data_o;

  int n_asserts = 0;
  int n_fail    = 0;

  // Model state, one variable per field.
  int m_send, m_cs, m_all1, m_tx, m_rx;

  reg_control_spi #(.DATA_WIDTH(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .data_1_i     (data_1_i),
    .wr_1_i       (wr_1_i),
    .n_rx_end_i   (n_rx_end_i),
    .wr_2_i       (wr_2_i),
    .send_clear_i (send_clear_i),
    .data_o       (data_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] model_image();
    int v;
    v = m_send + 2 * m_cs + 4 * m_all1 + 16 * m_tx + 65536 * m_rx;
    return 32'(v);
  endfunction

  task automatic model_edge();
    int d;
    if (rst_i) begin
      m_send = 0; m_cs = 0; m_all1 = 0; m_tx = 0; m_rx = 0;
    end else if (wr_1_i) begin
      d      = int'(data_1_i);
      m_send = (d >> 0) & 1;
      m_cs   = (d >> 1) & 1;
      m_all1 = (d >> 2) & 1;
      m_tx   = (d >> 4) & 511;
      m_rx   = (d >> 16) & 1023;
    end else begin
      if (wr_2_i)       m_rx   = int'(n_rx_end_i);
      if (send_clear_i) m_send = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] expected);
    n_asserts++;
    assert (data_o === expected)
      else begin
        n_fail++;
        $error("FAIL %s: data_o=%h expected=%h", tag, data_o, expected);
      end
  endtask

  task automatic idle_inputs();
    rst_i = 1'b0; data_1_i = '0; wr_1_i = 1'b0;
    n_rx_end_i = '0; wr_2_i = 1'b0; send_clear_i = 1'b0;
  endtask

  initial begin
    logic [31:0] prev;
    m_send = 0; m_cs = 0; m_all1 = 0; m_tx = 0; m_rx = 0;

    // Reset with arbitrary inputs active
    rst_i = 1'b1; data_1_i = 32'hFFFF_FFFF; wr_1_i = 1'b1;
    n_rx_end_i = 10'h3FF; wr_2_i = 1'b1; send_clear_i = 1'b0;
    tick();
    check("reset", 32'h0000_0000);

    idle_inputs();
    data_1_i = 32'd25; wr_1_i = 1'b1;
    tick();
    check("sw_write", 32'h0000_0011);

    idle_inputs();
    send_clear_i = 1'b1;
    tick();
    check("send_clear", 32'h0000_0010);

    idle_inputs();
    n_rx_end_i = 10'd31;
    tick();
    check("rx_no_wr2", 32'h0000_0010);

    wr_2_i = 1'b1; n_rx_end_i = 10'd63;
    tick();
    check("engine_write", 32'h003F_0010);

    wr_2_i = 1'b0; n_rx_end_i = 10'd0;
    tick();
    check("engine_hold", 32'h003F_0010);

    // wr_1 beats both engine updates
    wr_1_i = 1'b1; data_1_i = 32'd25; send_clear_i = 1'b1;
    wr_2_i = 1'b1; n_rx_end_i = 10'd127;
    tick();
    check("priority_wr1", 32'h0000_0011);

    wr_1_i = 1'b0; wr_2_i = 1'b0;
    tick();
    check("priority_clear", 32'h0000_0010);
    tick();
    check("clear_level_hold", 32'h0000_0010);

    idle_inputs();
    data_1_i = 32'hFFFF_FFFF; wr_1_i = 1'b1;
    tick();
    check("reserved_mask", 32'h03FF_1FF7);

    data_1_i = 32'h0000_0005;
    tick();
    check("wr1_reload", 32'h0000_0005);

    rst_i = 1'b1; data_1_i = 32'hFFFF_FFFF;
    tick();
    check("reset_over_wr1", 32'h0000_0000);

    idle_inputs();
    data_1_i = 32'h0000_0013; wr_1_i = 1'b1;
    tick();
    check("set_send_cs", 32'h0000_0013);

    idle_inputs();
    wr_2_i = 1'b1; n_rx_end_i = 10'h3FF; send_clear_i = 1'b1;
    tick();
    check("wr2_and_clear", 32'h03FF_0012);

    idle_inputs();
    tick();
    check("idle_hold", 32'h03FF_0012);

    // Random traffic against the field model
    for (int i = 0; i < 500; i++) begin
      prev         = data_o;
      rst_i        = ($urandom_range(0, 31) == 0);
      wr_1_i       = ($urandom_range(0, 3) == 0);
      wr_2_i       = ($urandom_range(0, 1) == 0);
      send_clear_i = ($urandom_range(0, 2) == 0);
      data_1_i     = $urandom;
      n_rx_end_i   = 10'($urandom);
      #1;
      check("no_comb_path", prev);
      tick();
      check("random", model_image());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
